// File: rtl/mem_dump_reader.sv
// Readback engine for the unified instruction/data memory: while the CPU is halted it
// streams a host-selected address range out of memory port 1 as a valid/ready word stream.
module mem_dump_reader #(
  parameter int unsigned ADRS_W     = 11,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic              start,
  input  logic [ADRS_W-1:0] start_adrs,
  input  logic [ADRS_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADRS_W-1:0] mem_radrs,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic [ADRS_W-1:0] dout_adrs,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int unsigned LEN_W = ADRS_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADRS_W-1:0] adrs;
    logic [DATA_W-1:0] data;
  } word_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [ADRS_W-1:0] cur_adrs, cur_adrs_nxt;
  logic              busy_nxt, done_nxt, aborted_nxt;
  logic              issue_c, flush_c, credit_ok_c;
  logic              push_c, pop_c;
  logic              inflight;
  logic [ADRS_W-1:0] inflight_adrs;
  word_t             fifo_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  fifo_count, fifo_count_nxt;
  logic [IDX_W-1:0]  push_idx_c;
  word_t             push_word_c;

  assign pop_c  = dout_valid & dout_ready;
  assign push_c = inflight;

  // A slot freed by this cycle's pop can be re-issued immediately, which keeps
  // the stream at one word per cycle with only two buffer entries.
  assign credit_ok_c = (CRD_W'(fifo_count) + CRD_W'(inflight))
                     < (CRD_W'(FIFO_DEPTH) + CRD_W'(pop_c));

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    cur_adrs_nxt  = cur_adrs;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    aborted_nxt   = 1'b0;
    issue_c       = 1'b0;
    flush_c       = 1'b0;

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (start && !cpu_en) begin
          cur_adrs_nxt  = start_adrs;
          remaining_nxt = length;
          if (length == '0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_READ;
            busy_nxt  = 1'b1;
          end
        end
      end

      S_READ: begin
        if (cpu_en) begin
          state_nxt   = S_IDLE;
          flush_c     = 1'b1;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
        end else if ((remaining != '0) && credit_ok_c) begin
          issue_c       = 1'b1;
          remaining_nxt = remaining - LEN_W'(1);
          cur_adrs_nxt  = cur_adrs + ADRS_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_nxt = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (cpu_en) begin
          state_nxt   = S_IDLE;
          flush_c     = 1'b1;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
        end else if (!inflight &&
                     ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop_c))) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Reset wins even in the cycle before its edge, so no read escapes.
  assign mem_r_en  = issue_c & ~resetn;
  assign mem_radrs = cur_adrs;

  // Control state, counters and the single read in flight.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state         <= S_IDLE;
      remaining     <= '0;
      cur_adrs      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      inflight      <= 1'b0;
      inflight_adrs <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      cur_adrs  <= cur_adrs_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      aborted   <= aborted_nxt;
      inflight  <= issue_c;
      if (issue_c) begin
        inflight_adrs <= cur_adrs;
      end
    end
  end

  assign fifo_count_nxt = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
  assign push_idx_c     = IDX_W'(fifo_count - CNT_W'(pop_c));
  assign push_word_c    = '{adrs: inflight_adrs, data: mem_rdata};

  // Shift-down output buffer: entry 0 is always the head, so dout is a flop.
  always_ff @(posedge clk) begin
    if (resetn || flush_c) begin
      fifo_count <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (pop_c) begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
          fifo_q[i] <= fifo_q[i+1];
        end
      end
      if (push_c) begin
        fifo_q[push_idx_c] <= push_word_c;
      end
      fifo_count <= fifo_count_nxt;
      dout_valid <= (fifo_count_nxt != '0);
    end
  end

  assign dout      = fifo_q[0].data;
  assign dout_adrs = fifo_q[0].adrs;

  // The credit rule must never let a push land on a full buffer.
  always_ff @(posedge clk) begin
    if (!resetn && !flush_c && push_c && !pop_c) begin
      assert (fifo_count < CNT_W'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: queue-based stream model checked every cycle, plus
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mem_dump_reader;

  localparam int unsigned ADRS_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int          DEPTH  = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              cpu_en = 1'b0;
  logic              start = 1'b0;
  logic [ADRS_W-1:0] start_adrs = '0;
  logic [ADRS_W:0]   length = '0;
  logic              busy, done, aborted;
  logic [ADRS_W-1:0] mem_radrs;
  logic              mem_r_en;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] dout;
  logic [ADRS_W-1:0] dout_adrs;
  logic              dout_valid;
  logic              dout_ready = 1'b1;

  always #5 clk = ~clk;

  mem_dump_reader #(.ADRS_W(ADRS_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .start(start),
    .start_adrs(start_adrs), .length(length), .busy(busy), .done(done),
    .aborted(aborted), .mem_radrs(mem_radrs), .mem_r_en(mem_r_en),
    .mem_rdata(mem_rdata), .dout(dout), .dout_adrs(dout_adrs),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  function automatic logic [31:0] mem_val(input logic [10:0] a);
    return {16'hC0DE, 5'b0, a};
  endfunction

  // One-cycle-latency memory port.
  always @(posedge clk) if (mem_r_en) mem_rdata <= mem_val(mem_radrs);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state and observation log.
  bit          m_busy, m_done, m_abort, nb, nd, na, accept, rst_prev;
  logic [10:0] exp_q[$];
  logic [10:0] iss_q[$];
  int          iss_tm1, iss_tm2, acc_cnt, occ;
  bit          prev_valid, prev_ready;
  logic [31:0] prev_dout;
  logic [10:0] prev_adrs;
  logic [10:0] log_adrs[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          n_done, n_abort, n_rd, done_cyc, abort_cyc, first_valid_cyc;
  int          ready_mode = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) dout_ready = ~dout_ready;
      else dout_ready = 1'b1;
    end
  end

  // Cycle-by-cycle compare against the stream model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_prev)
        chk("reset_outputs", {busy, done, aborted, dout_valid, mem_r_en, dout, dout_adrs, mem_radrs}, '0);
      rst_prev = resetn;
      if (resetn) begin
        m_busy = 0; m_done = 0; m_abort = 0;
        exp_q.delete(); iss_q.delete();
        iss_tm1 = 0; iss_tm2 = 0; acc_cnt = 0;
        prev_valid = 0; prev_ready = 0;
        continue;
      end

      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("aborted", aborted, m_abort);
      if (cpu_en) chk("rd_while_cpu_en", mem_r_en, 0);
      if (mem_r_en) begin
        n_rd++;
        chk("rd_pending", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) chk("rd_adrs", mem_radrs, iss_q.pop_front());
      end

      occ = iss_tm2 - acc_cnt;
      chk("occupancy_le_depth", occ <= DEPTH, 1);
      chk("dout_valid", dout_valid, occ != 0);
      if (prev_valid && !prev_ready && !m_abort)
        chk("head_stable", {dout_valid, dout_adrs, dout}, {1'b1, prev_adrs, prev_dout});
      if (dout_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        chk("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("dout_adrs", dout_adrs, exp_q[0]);
          chk("dout", dout, mem_val(exp_q[0]));
        end
      end

      accept = dout_valid && dout_ready;
      if (accept) begin
        log_adrs.push_back(dout_adrs); log_data.push_back(dout); log_cyc.push_back(cyc);
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (aborted) begin n_abort++; abort_cyc = cyc; end

      nb = m_busy; nd = 0; na = 0;
      if (m_busy && cpu_en) begin
        na = 1; nb = 0;
        exp_q.delete(); iss_q.delete();
        iss_tm1 = 0; iss_tm2 = 0; acc_cnt = 0;
      end else begin
        iss_tm2 = iss_tm1;
        iss_tm1 += int'(mem_r_en);
        if (accept) begin
          acc_cnt++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (m_busy && exp_q.size() == 0) begin nd = 1; nb = 0; end
        end
      end
      if (!m_busy && !m_done && start && !cpu_en) begin
        if (length == 0) nd = 1;
        else begin
          nb = 1;
          for (int i = 0; i < int'(length); i++) begin
            exp_q.push_back(11'(start_adrs + 11'(i)));
            iss_q.push_back(11'(start_adrs + 11'(i)));
          end
        end
      end
      m_busy = nb; m_done = nd; m_abort = na;
      prev_valid = dout_valid; prev_ready = dout_ready;
      prev_dout = dout; prev_adrs = dout_adrs;
    end
  end

  task automatic clear_log();
    log_adrs.delete(); log_data.delete(); log_cyc.delete();
    n_done = 0; n_abort = 0; n_rd = 0;
    done_cyc = -1; abort_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic pulse_start(input logic [10:0] a, input logic [11:0] len, output int st);
    @(posedge clk); #1;
    start = 1'b1; start_adrs = a; length = len; st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int maxc);
    bit seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(posedge clk); #1;
      if (n_done > 0 || n_abort > 0) seen = 1;
    end
    chk({"finish_", name}, seen, 1);
  endtask

  task automatic wait_log(input string name, input int n, input int maxc);
    bit seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(posedge clk); #1;
      if (log_adrs.size() >= n) seen = 1;
    end
    chk({"accepts_", name}, seen, 1);
  endtask

  int          st, ab_cyc;
  logic [10:0] a4[4];
  logic [31:0] d4[4];

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);

    // Basic 4-word dump at full rate.
    clear_log();
    pulse_start(11'h010, 12'd4, st);
    wait_end("basic", 30);
    a4 = '{11'h010, 11'h011, 11'h012, 11'h013};
    d4 = '{32'hC0DE0010, 32'hC0DE0011, 32'hC0DE0012, 32'hC0DE0013};
    chk("basic_count", log_adrs.size(), 4);
    if (log_adrs.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("basic_adrs", log_adrs[i], a4[i]);
        chk("basic_data", log_data[i], d4[i]);
      end
      chk("basic_back_to_back", log_cyc[3] - log_cyc[0], 3);
      chk("basic_done_after_last", done_cyc - log_cyc[3], 1);
    end
    chk("basic_latency", first_valid_cyc - st, 3);
    chk("basic_reads", n_rd, 4);

    // Backpressure with ready toggling.
    clear_log();
    ready_mode = 1;
    pulse_start(11'h100, 12'd6, st);
    wait_end("backpressure", 80);
    chk("bp_count", log_adrs.size(), 6);
    for (int i = 0; i < 6 && i < log_adrs.size(); i++)
      chk("bp_adrs", log_adrs[i], 11'h100 + 11'(i));
    chk("bp_reads", n_rd, 6);
    ready_mode = 0;

    // Address wrap.
    clear_log();
    pulse_start(11'h7FE, 12'd4, st);
    wait_end("wrap", 30);
    a4 = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    chk("wrap_count", log_adrs.size(), 4);
    if (log_adrs.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("wrap_adrs", log_adrs[i], a4[i]);
      chk("wrap_data_zero", log_data[2], 32'hC0DE0000);
    end

    // Zero length.
    clear_log();
    pulse_start(11'h123, 12'd0, st);
    wait_end("zero_len", 10);
    chk("zero_len_done_next", done_cyc - st, 1);
    chk("zero_len_reads", n_rd, 0);
    chk("zero_len_words", log_adrs.size(), 0);

    // Start while busy is ignored.
    clear_log();
    pulse_start(11'h020, 12'd8, st);
    start = 1'b1; start_adrs = 11'h300; length = 12'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_end("busy_start", 40);
    repeat (5) @(posedge clk);
    chk("busy_start_count", log_adrs.size(), 8);
    if (log_adrs.size() == 8) chk("busy_start_last", log_adrs[7], 11'h027);
    chk("busy_start_reads", n_rd, 8);
    chk("busy_start_dones", n_done, 1);

    // Start with cpu_en high is ignored.
    clear_log();
    cpu_en = 1'b1;
    pulse_start(11'h050, 12'd3, st);
    repeat (4) @(posedge clk);
    #1 chk("cpu_en_start_busy", busy, 0);
    chk("cpu_en_start_reads", n_rd, 0);
    chk("cpu_en_start_done", n_done, 0);
    cpu_en = 1'b0;

    // Abort after the 5th accept.
    clear_log();
    pulse_start(11'h040, 12'd16, st);
    wait_log("abort", 5, 40);
    cpu_en = 1'b1; ab_cyc = cyc;
    wait_end("abort", 10);
    chk("abort_pulses", n_abort, 1);
    chk("abort_no_done", n_done, 0);
    chk("abort_pulse_next", abort_cyc - ab_cyc, 1);
    chk("abort_words_cut", log_adrs.size() <= 6, 1);
    if (log_adrs.size() >= 5) chk("abort_5th_adrs", log_adrs[4], 11'h044);
    repeat (3) @(posedge clk);
    chk("abort_valid_low", dout_valid, 0);
    cpu_en = 1'b0;

    // Reset mid-dump.
    clear_log();
    pulse_start(11'h080, 12'd16, st);
    wait_log("reset", 3, 30);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("reset_no_done", n_done, 0);
    chk("reset_no_abort", n_abort, 0);
    chk("reset_idle", {busy, dout_valid}, 0);

    // Recovery after reset.
    clear_log();
    pulse_start(11'h005, 12'd3, st);
    wait_end("recover", 30);
    chk("recover_count", log_adrs.size(), 3);
    if (log_adrs.size() == 3) chk("recover_first", log_adrs[0], 11'h005);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
